// File: rtl/ps2_frame_rx.sv
// PS/2 keyboard receiver: line sync + glitch filter, 11-bit frame FSM, E0/F0 prefix resolution, key-held level.
// Optional in-frame idle timeout is compiled in when PS2_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module ps2_frame_rx #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       CLK_50M,
  input  logic       RST_N,
  input  logic       ps2k_clk,
  input  logic       ps2k_data,
  output logic [7:0] ps2_byte,
  output logic       byte_valid,
  output logic       break_flag,
  output logic       ext_flag,
  output logic       ps2_state,
  output logic       parity_err,
  output logic       frame_err
);

  localparam int unsigned FCW        = $clog2(FILTER_LEN + 1);
  localparam logic [7:0]  CODE_BREAK = 8'hF0;
  localparam logic [7:0]  CODE_EXT   = 8'hE0;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_e;

  // bit 0 = clock line, bit 1 = data line
  logic [1:0]     meta_q, sync_q, filt_q, filt_d;
  logic [FCW-1:0] cnt_q [2];
  logic [FCW-1:0] cnt_d [2];
  logic           clk_prev_q;
  logic           sample_c;
  logic           bit_c;
  logic           tmo_hit_c;

  state_e     state_q;
  logic [7:0] shift_q;
  logic [2:0] bit_cnt_q;
  logic       parity_q;
  logic       break_pend_q, ext_pend_q;
  logic [7:0] held_q;
  logic [7:0] byte_q;
  logic       valid_q, brk_q, ext_q, held_lvl_q, perr_q, ferr_q;

  // Filtered value flips only after FILTER_LEN consecutive differing samples
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      filt_d[i] = filt_q[i];
      cnt_d[i]  = '0;
      if (sync_q[i] != filt_q[i]) begin
        if (cnt_q[i] == FCW'(FILTER_LEN - 1)) filt_d[i] = sync_q[i];
        else                                  cnt_d[i]  = cnt_q[i] + FCW'(1);
      end
    end
  end

  // Reset to idle-high so no false falling edge follows reset
  always_ff @(posedge CLK_50M) begin
    if (!RST_N) begin
      meta_q     <= 2'b11;
      sync_q     <= 2'b11;
      filt_q     <= 2'b11;
      clk_prev_q <= 1'b1;
      cnt_q[0]   <= '0;
      cnt_q[1]   <= '0;
    end else begin
      meta_q     <= {ps2k_data, ps2k_clk};
      sync_q     <= meta_q;
      filt_q     <= filt_d;
      clk_prev_q <= filt_q[0];
      cnt_q[0]   <= cnt_d[0];
      cnt_q[1]   <= cnt_d[1];
    end
  end

  assign sample_c = clk_prev_q & ~filt_q[0];
  assign bit_c    = filt_q[1];

`ifdef PS2_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] tmo_cnt_q;

  assign tmo_hit_c = (state_q != S_IDLE) && !sample_c && (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK_50M) begin
    if (!RST_N || state_q == S_IDLE || sample_c || tmo_hit_c) tmo_cnt_q <= '0;
    else                                                      tmo_cnt_q <= tmo_cnt_q + TW'(1);
  end
`else
  assign tmo_hit_c = 1'b0;
  if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
  end
`endif

  // Frame FSM, prefix tracking and registered outputs
  always_ff @(posedge CLK_50M) begin
    if (!RST_N) begin
      state_q      <= S_IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      parity_q     <= 1'b0;
      break_pend_q <= 1'b0;
      ext_pend_q   <= 1'b0;
      held_q       <= '0;
      byte_q       <= '0;
      valid_q      <= 1'b0;
      brk_q        <= 1'b0;
      ext_q        <= 1'b0;
      held_lvl_q   <= 1'b0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      if (tmo_hit_c) begin
        state_q      <= S_IDLE;
        break_pend_q <= 1'b0;
        ext_pend_q   <= 1'b0;
        ferr_q       <= 1'b1;
      end else if (sample_c) begin
        case (state_q)
          S_IDLE: begin
            if (!bit_c) begin
              bit_cnt_q <= '0;
              state_q   <= S_DATA;
            end
          end
          S_DATA: begin
            shift_q   <= {bit_c, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_q <= S_PARITY;
          end
          S_PARITY: begin
            parity_q <= bit_c;
            state_q  <= S_STOP;
          end
          S_STOP: begin
            state_q <= S_IDLE;
            if (!bit_c) begin
              ferr_q       <= 1'b1;
              break_pend_q <= 1'b0;
              ext_pend_q   <= 1'b0;
            end else if (!(^{shift_q, parity_q})) begin
              perr_q       <= 1'b1;
              break_pend_q <= 1'b0;
              ext_pend_q   <= 1'b0;
            end else if (shift_q == CODE_BREAK) begin
              break_pend_q <= 1'b1;
            end else if (shift_q == CODE_EXT) begin
              ext_pend_q <= 1'b1;
            end else begin
              byte_q       <= shift_q;
              brk_q        <= break_pend_q;
              ext_q        <= ext_pend_q;
              valid_q      <= 1'b1;
              break_pend_q <= 1'b0;
              ext_pend_q   <= 1'b0;
              // A break only releases the key currently held
              if (!break_pend_q) begin
                held_lvl_q <= 1'b1;
                held_q     <= shift_q;
              end else if (shift_q == held_q) begin
                held_lvl_q <= 1'b0;
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign ps2_byte   = byte_q;
  assign byte_valid = valid_q;
  assign break_flag = brk_q;
  assign ext_flag   = ext_q;
  assign ps2_state  = held_lvl_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;

endmodule

// File: doc/ps2_frame_rx.md
# ps2_frame_rx

Receives raw PS/2 keyboard clock/data lines and deserialises 11-bit frames into scan-code bytes. Also resolves the E0 (extended) and F0 (break) prefixes into flags and maintains a key-held level. Sits directly upstream of the keyboard decoding stage, which consumes `ps2_byte` and `ps2_state` to generate left/right/down/play/restart key-press pulses for the game.

## Interface

Parameters:
- `FILTER_LEN`, default 8: consecutive identical synchronised samples required before the filtered PS/2 clock or data changes.
- `TIMEOUT_CYCLES`, default 50000: idle-cycle limit inside a frame (1 ms at 50 MHz). Used only with `PS2_TIMEOUT_EN`.

Ports:
- `CLK_50M` input 1: system clock. Single clock domain.
- `RST_N` input 1: synchronous, active-low reset.
- `ps2k_clk` input 1: raw PS/2 clock. Asynchronous, idles high.
- `ps2k_data` input 1: raw PS/2 data. Asynchronous, idles high.
- `ps2_byte` output 8: last delivered scan code, with prefixes stripped.
- `byte_valid` output 1: one-cycle strobe. `ps2_byte` and the flags are valid on this cycle.
- `break_flag` output 1: the delivered byte was preceded by F0.
- `ext_flag` output 1: the delivered byte was preceded by E0.
- `ps2_state` output 1: key-held level.
- `parity_err` output 1: one-cycle strobe when a frame fails the odd-parity check.
- `frame_err` output 1: one-cycle strobe on a bad stop bit or a timeout.

## Operation

**Input conditioning**
- Each raw line passes through a 2-FF synchroniser.
- Then a glitch filter: the filtered value flips only after `FILTER_LEN` consecutive samples that differ from the current filtered value.
- A sample event is one cycle where filtered clock goes 1 to 0. Filtered data is sampled on that cycle.

**FSM** (states IDLE, DATA, PARITY, STOP):
- IDLE: a sample with data=0 (start bit) clears the bit counter and moves to DATA. A sample with data=1 is ignored; stay in IDLE.
- DATA: each sample shifts the data bit into the shift register MSB-side (shift right), so data arrives LSB first. The 3-bit counter increments; after the 8th bit, go to PARITY.
- PARITY: store the bit and go to STOP.
- STOP: on the sample, evaluate the frame and always return to IDLE:
  - Stop bit = 0: `frame_err` pulse, pending flags cleared.
  - Else, if XOR of the 8 data bits and the parity bit is 0: `parity_err` pulse, pending flags cleared.
  - Else, byte = F0: set `break_pend`, no output.
  - Else, byte = E0: set `ext_pend`, no output.
  - Otherwise: deliver the byte. Load `ps2_byte`, `break_flag`=`break_pend`, `ext_flag`=`ext_pend`, pulse `byte_valid`, then clear both pending flags.

**`ps2_state`**
- Set on delivery of a make code (`break_flag`=0).
- Cleared on delivery of a break code whose byte equals the held byte.
- A break code for a different byte leaves it unchanged.

**Simultaneous events**
- A prefix received while already pending keeps it set.
- E0 and F0 both pending is legal (extended break).

## Timing

**Reset**
- `RST_N`=0 at a rising edge puts every output to 0, FSM to IDLE, and pending flags to 0.
- Synchroniser and filter registers reset to 1 so no edge is detected after reset.
- Reset mid-frame discards the partial frame with no error strobe.

**Latency and pulses**
- A physical clock fall becomes a sample event 2 + `FILTER_LEN` cycles later (±1).
- `byte_valid` and the error strobes assert the cycle after the stop-bit sample event, for exactly 1 cycle.
- `ps2_byte` and the flags hold until the next delivery. `ps2_state` updates in the same cycle as `byte_valid`.
- At most one of `byte_valid`, `parity_err`, `frame_err` is high in any cycle.
- No back-pressure. The consumer must accept `byte_valid` on the cycle it is high.

## Configuration

`PS2_TIMEOUT_EN`:
- **Defined:** a counter of width `$clog2(TIMEOUT_CYCLES)` clears on every sample event and while in IDLE, and increments otherwise. Reaching `TIMEOUT_CYCLES-1` forces IDLE, clears the pending flags and pulses `frame_err` the next cycle.
- **Undefined:** no counter exists. A truncated frame stalls until the following bits complete it, and `frame_err` comes only from the stop bit.

## Test plan

Bench drives PS/2 at half-period 2000 cycles; data changes mid-high phase.

1. Frame 0x4D (bits 0,1,0,1,1,0,0,1,0, parity 1, stop 1) -> `byte_valid` 1 cycle, `ps2_byte`=0x4D, `break_flag`=0, `ext_flag`=0, `ps2_state`=1.
2. E0, 6B (parity 0), then E0, F0, 6B -> first delivery: 0x6B with `ext_flag`=1, `ps2_state`=1. Second delivery: 0x6B with `ext_flag`=1, `break_flag`=1, `ps2_state`=0. No strobes on prefix bytes.
3. 0x2D sent with parity bit 0 -> `parity_err` 1 cycle, no `byte_valid`. A following good 0x2D frame is delivered with `break_flag`=0.
4. With `PS2_TIMEOUT_EN`, stop driving after 4 data bits -> `frame_err` pulse about 50000 cycles after the last fall, FSM in IDLE. A subsequent 0x4D frame decodes correctly.
5. Clock glitch low for `FILTER_LEN`-2 cycles while idle -> no state change and no strobes. A stop bit driven 0 -> `frame_err` only.
6. `RST_N` low for 1 cycle after 5 data bits -> all outputs 0. The remainder of that frame raises no strobes (no start bit); the next full frame decodes correctly.
